// File: rtl/regfile_pkg.sv
// Shared register-file types for the writeback path.
//   REG_AW / REG_DW / NUM_REGS : register file geometry
//   reg_addr_t / reg_data_t    : address and data words
//   wb_req_t                   : one writeback request {rd, data}
//   wb_src_e                   : which writeback source owns the write port
package regfile_pkg;
  localparam int REG_AW   = 4;
  localparam int REG_DW   = 16;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_req_t;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared once
// the write has been presented to the register file.
//   set_en/set_rd : mark a destination as outstanding (wins over a clear)
//   clr_en/clr_rd : retire an outstanding destination
//   ra1/ra2       : hazard lookups -> hz1/hz2 (r0 never hazards)
//   chk_rd        : issue check -> chk_ok (free, or r0)
//   pending       : the scoreboard register
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  reg_addr_t           set_rd,
  input  logic                clr_en,
  input  reg_addr_t           clr_rd,
  input  reg_addr_t           ra1,
  input  reg_addr_t           ra2,
  input  reg_addr_t           chk_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                hz1,
  output logic                hz2,
  output logic                chk_ok
);
  logic [NUM_REGS-1:0] pending_nxt;

  // Clear first, then set, so a re-issue on the retiring register keeps its bit.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_rd] = 1'b0;
    if (set_en) pending_nxt[set_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign hz1    = pending[ra1] && (ra1 != '0);
  assign hz2    = pending[ra2] && (ra2 != '0);
  assign chk_ok = !pending[chk_rd] || (chk_rd == '0);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and LSU writeback, with a
// starvation guard for the ALU, and tracks outstanding destinations.
//   issue_*      : decode issue handshake (blocked on WAW)
//   alu_* / lsu_*: writeback requests, valid/ready handshake
//   ra1/ra2      : decode read addresses -> hz1/hz2 stall flags
//   we3/wa3/wd3  : registered register file write port
//   pending      : scoreboard, for debug/perf
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DW       = REG_DW,
  parameter int AW       = REG_AW,
  parameter int MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                alu_valid,
  input  logic [AW-1:0]       alu_rd,
  input  logic [DW-1:0]       alu_data,
  output logic                alu_ready,
  input  logic                lsu_valid,
  input  logic [AW-1:0]       lsu_rd,
  input  logic [DW-1:0]       lsu_data,
  output logic                lsu_ready,
  input  logic [AW-1:0]       ra1,
  input  logic [AW-1:0]       ra2,
  output logic                hz1,
  output logic                hz2,
  output logic                we3,
  output logic [AW-1:0]       wa3,
  output logic [DW-1:0]       wd3,
  output logic [NUM_REGS-1:0] pending
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] alu_wait;
  wb_src_e       src;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;
  logic          sb_hz1, sb_hz2, sb_ok;

  // LSU has priority; ALU takes over once it has lost MAX_WAIT times in a row.
  always_comb begin
    src = WB_NONE;
    if (!rst) begin
      if (alu_valid && (!lsu_valid || alu_wait == WW'(MAX_WAIT))) src = WB_ALU;
      else if (lsu_valid)                                          src = WB_LSU;
    end
  end

  assign alu_ready = (src == WB_ALU);
  assign lsu_ready = (src == WB_LSU);

  always_comb begin
    sel_rd   = lsu_rd;
    sel_data = lsu_data;
    if (src == WB_ALU) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wait <= '0;
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
    end else begin
      if (!alu_valid || src == WB_ALU)    alu_wait <= '0;
      else if (alu_wait != WW'(MAX_WAIT)) alu_wait <= alu_wait + WW'(1);
      // r0 writes complete the handshake but never strobe the file.
      we3 <= (src != WB_NONE) && (sel_rd != '0);
      if (src != WB_NONE) begin
        wa3 <= sel_rd;
        wd3 <= sel_data;
      end
    end
  end

  regfile_scoreboard u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (issue_valid && issue_ready && (issue_rd != '0)),
    .set_rd (issue_rd),
    .clr_en (we3),
    .clr_rd (wa3),
    .ra1    (ra1),
    .ra2    (ra2),
    .chk_rd (issue_rd),
    .pending(pending),
    .hz1    (sb_hz1),
    .hz2    (sb_hz2),
    .chk_ok (sb_ok)
  );

  assign issue_ready = !rst && sb_ok;
  assign hz1         = !rst && sb_hz1;
  assign hz2         = !rst && sb_hz2;
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port (wa3/wd3/we3) between two writeback sources: the ALU and the load unit (LSU).
- Tracks outstanding destination writes in a 16-entry pending scoreboard. This blocks WAW issue and flags RAW hazards on the two read addresses.
- Sits between the issue/decode stage, the execution units, and the register file.
- Registers the write port, so the register file sees a clean, single-cycle write strobe.

## Interface
Parameters:
- DW, 16, data width (matches register file)
- AW, 4, register address width (16 registers)
- MAX_WAIT, 3, consecutive lost arbitrations after which the ALU is forced to win

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  decode issues an instruction with a destination
- issue_rd  in  AW  destination register of the issued instruction
- issue_ready  out  1  issue accepted this cycle
- alu_valid  in  1  ALU result available
- alu_rd  in  AW  ALU destination
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- lsu_valid  in  1  load data available
- lsu_rd  in  AW  load destination
- lsu_data  in  DW  load data
- lsu_ready  out  1  load data accepted this cycle
- ra1, ra2  in  AW  read addresses presented to the register file
- hz1, hz2  out  1  pending write to ra1 / ra2; decode must stall
- we3  out  1  register file write enable (registered)
- wa3  out  AW  register file write address (registered)
- wd3  out  DW  register file write data (registered)
- pending  out  16  scoreboard bit vector, for debug and perf

## Operation
- **Issue:**
  - issue_ready = !pending[issue_rd] || issue_rd == 0.
  - On issue_valid && issue_ready with issue_rd != 0, pending[issue_rd] is set at the next edge.
  - issue_rd == 0 never sets a bit.
- **Arbitration** (combinational, each cycle):
  - If only one source is valid, it is granted.
  - If both are valid, the LSU wins unless alu_wait == MAX_WAIT, in which case the ALU wins.
  - ready = grant; a handshake is valid && ready. Sources hold rd/data stable while valid && !ready.
- **Starvation counter alu_wait** (range 0..MAX_WAIT):
  - Increments when alu_valid && !alu_ready.
  - Clears on ALU grant or when !alu_valid.
  - Saturates at MAX_WAIT.
- **Write stage:**
  - A granted handshake loads wa3/wd3 at the next edge.
  - we3 = 1 iff a source was granted and its rd != 0.
  - Writes to x0 are accepted (ready = 1) but produce we3 = 0.
  - With no grant, we3 = 0 and wa3/wd3 hold their previous values.
- **Scoreboard clear:** pending[wa3] clears at the edge after the cycle in which we3 = 1 (one cycle after the write is presented to the register file).
- **Set and clear on the same edge, same register:** the set wins (the new issue owns the bit).
- **Hazards:**
  - hz1 = pending[ra1] && ra1 != 0; hz2 likewise for ra2.
  - Combinational from the scoreboard register only; no bypass through the we3 cycle.
- **Reset:** pending = 0, alu_wait = 0, we3 = 0, wa3 = 0, wd3 = 0.
  - Reset mid-operation discards in-flight writes and all pending bits.
  - During rst, all ready outputs and issue_ready are 0; hz1/hz2 are 0.

## Timing
- Latency: writeback handshake at cycle N → we3/wa3/wd3 valid in cycle N+1 → register file writes at the end of N+1 → pending bit clears at the same edge → hz deasserts in N+2.
- A dependent reader stalls until N+2 and then reads the written value from the register file.
- Throughput: one register file write per cycle. The losing source waits at least one cycle.
- Worst-case ALU wait with continuous LSU traffic is MAX_WAIT cycles; grant then occurs in cycle MAX_WAIT+1 of waiting.
- No combinational path from the we3/wa3/wd3 outputs to any input.
- ready outputs depend combinationally on the valids and alu_wait only.

## Structure
- Shared package regfile_pkg:
  - REG_AW, REG_DW, NUM_REGS.
  - typedef reg_addr_t, reg_data_t.
  - typedef wb_req_t struct {rd, data}.
  - enum wb_src_e {WB_NONE, WB_ALU, WB_LSU}.
- One natural sub-module, regfile_scoreboard:
  - 16-bit pending register with set/clear ports and set-priority.
  - Exposes two hazard lookups and the issue check.
- Arbiter, starvation counter and output register stay in the top module.

## Test plan
- Issue r3, ALU writes r3 = 0x1234 → we3 = 1, wa3 = 3, wd3 = 0x1234 in the next cycle. pending[3] is 1 through that cycle and 0 after. With ra1 = 3, hz1 deasserts two cycles after the handshake.
- ALU (r1 = 0x00AA) and LSU (r2 = 0x00BB) valid together → LSU is written first, ALU in the following cycle. The ALU waits exactly one cycle.
- LSU valid every cycle, ALU valid continuously, MAX_WAIT = 3 → ALU is granted on its 4th cycle of waiting. The LSU stalls that one cycle.
- Issue r5, then issue r5 again before writeback → second issue_ready = 0 until pending[5] clears.
- Writeback to r0 with data 0xFFFF → alu_ready = 1, we3 = 0. Issue to r0 never sets pending. hz1 = 0 for ra1 = 0.
- pending = 0x0030 with a write to r4 in flight, then rst pulsed for one cycle → we3 = 0 at the next edge, pending = 0, hz1/hz2 = 0, all ready outputs 0 during reset.
